// File: rtl/embedded_cpumaster_cpu_div_cell_if.sv
// Execute-stage request/response bundle between the CPU pipeline and the divider cell.
interface embedded_cpumaster_cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_div_start;
  logic             E_div_signed;
  logic             E_div_abort;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed, E_div_abort,
    input  div_busy, div_done, div_quotient, div_remainder
  );

  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed, E_div_abort,
    output div_busy, div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/embedded_cpumaster_cpu_div_cell.sv
// Radix-2 restoring divider: magnitudes are divided over WIDTH cycles, then signs are
// restored in a final fixup cycle that also loads the held result registers.
module embedded_cpumaster_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  embedded_cpumaster_cpu_div_cell_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quo_out_q, quo_out_d;
  logic [WIDTH-1:0]   rem_out_q, rem_out_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    raw_d     = raw_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    done_d    = 1'b0;

    // One restoring step: the remainder never exceeds the divisor, so WIDTH+1 bits suffice.
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dsr_q};

    unique case (state_q)
      IDLE: begin
        if (bus.E_div_start && !bus.E_div_abort) begin
          dvd_d     = magnitude(bus.E_src1, bus.E_div_signed);
          dsr_d     = magnitude(bus.E_src2, bus.E_div_signed);
          neg_quo_d = bus.E_div_signed && (bus.E_src1[WIDTH-1] ^ bus.E_src2[WIDTH-1]);
          neg_rem_d = bus.E_div_signed && bus.E_src1[WIDTH-1];
          dz_d      = (bus.E_src2 == '0);
          raw_d     = bus.E_src1;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (bus.E_div_abort) begin
          state_d = IDLE;
        end else begin
          rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.E_div_abort) begin
          state_d = IDLE;
        end else begin
          // Divide by zero bypasses sign fixup and returns the untouched dividend.
          quo_out_d = dz_q ? '1    : apply_sign(dvd_q, neg_quo_q);
          rem_out_d = dz_q ? raw_q : apply_sign(rem_q, neg_rem_q);
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      raw_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      raw_q     <= raw_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.div_busy      = (state_q != IDLE);
  assign bus.div_done      = done_q;
  assign bus.div_quotient  = quo_out_q;
  assign bus.div_remainder = rem_out_q;

endmodule

// File: tb/tb_embedded_cpumaster_cpu_div_cell.sv
// Directed bench for the iterative divider: latency, signed/unsigned results, edge cases,
// abort, start-while-busy, asynchronous reset and back-to-back operation.
module tb_embedded_cpumaster_cpu_div_cell;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  embedded_cpumaster_cpu_div_cell_if #(.WIDTH(32)) bus ();

  embedded_cpumaster_cpu_div_cell #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Present a request and let the next rising edge accept it; returns #1 after that edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.E_src1       = a;
    bus.E_src2       = b;
    bus.E_div_signed = s;
    bus.E_div_start  = 1'b1;
    @(posedge clk);
    #1;
    bus.E_div_start  = 1'b0;
  endtask

  // Counts edges until done (bounded); lat stays 0 if done never shows up.
  task automatic wait_done(output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int bcyc);
    lat  = 0;
    q    = '0;
    r    = '0;
    bcyc = bus.div_busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.div_done) begin
        lat = i;
        q   = bus.div_quotient;
        r   = bus.div_remainder;
        break;
      end
      if (bus.div_busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    bus.E_src1 = '0; bus.E_src2 = '0; bus.E_div_start = 1'b0;
    bus.E_div_signed = 1'b0; bus.E_div_abort = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.div_busy); else passes++;
    checks++; if (bus.div_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.div_done); else passes++;
    checks++; if (bus.div_quotient !== 32'h0) $display("FAIL reset_quo got %h want 0", bus.div_quotient); else passes++;
    checks++; if (bus.div_remainder !== 32'h0) $display("FAIL reset_rem got %h want 0", bus.div_remainder); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", bus.div_busy); else passes++;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int lat, bcyc;
    launch(32'd100, 32'd7, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (lat !== 33) $display("FAIL u100_7_latency got %0d want 33", lat); else passes++;
    checks++; if (bcyc !== 33) $display("FAIL u100_7_busy_cycles got %0d want 33", bcyc); else passes++;
    checks++; if (q !== 32'd14) $display("FAIL u100_7_quo got %h want %h", q, 32'd14); else passes++;
    checks++; if (r !== 32'd2) $display("FAIL u100_7_rem got %h want %h", r, 32'd2); else passes++;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL u100_7_busy_at_done got %b want 0", bus.div_busy); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.div_done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", bus.div_done); else passes++;
    checks++; if (bus.div_quotient !== 32'd14) $display("FAIL quo_held got %h want %h", bus.div_quotient, 32'd14); else passes++;
  endtask

  task automatic test_signed();
    logic [31:0] q, r;
    int lat, bcyc;
    launch(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'hFFFF_FFFD) $display("FAIL sm7_2_quo got %h want FFFFFFFD", q); else passes++;
    checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL sm7_2_rem got %h want FFFFFFFF", r); else passes++;
    launch(32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'hFFFF_FFFD) $display("FAIL s7_m2_quo got %h want FFFFFFFD", q); else passes++;
    checks++; if (r !== 32'h0000_0001) $display("FAIL s7_m2_rem got %h want 00000001", r); else passes++;
    launch(32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'h7FFF_FFFC) $display("FAIL ubig_2_quo got %h want 7FFFFFFC", q); else passes++;
    checks++; if (r !== 32'h0000_0001) $display("FAIL ubig_2_rem got %h want 00000001", r); else passes++;
  endtask

  task automatic test_edge_cases();
    logic [31:0] q, r;
    int lat, bcyc;
    launch(32'h1234_5678, 32'h0, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (lat !== 33) $display("FAIL dz_u_latency got %0d want 33", lat); else passes++;
    checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL dz_u_quo got %h want FFFFFFFF", q); else passes++;
    checks++; if (r !== 32'h1234_5678) $display("FAIL dz_u_rem got %h want 12345678", r); else passes++;
    launch(32'h1234_5678, 32'h0, 1'b1);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL dz_s_quo got %h want FFFFFFFF", q); else passes++;
    checks++; if (r !== 32'h1234_5678) $display("FAIL dz_s_rem got %h want 12345678", r); else passes++;
    launch(32'hFFFF_FFF9, 32'h0, 1'b1);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL dz_neg_quo got %h want FFFFFFFF", q); else passes++;
    checks++; if (r !== 32'hFFFF_FFF9) $display("FAIL dz_neg_rem got %h want FFFFFFF9", r); else passes++;
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'h8000_0000) $display("FAIL ovf_quo got %h want 80000000", q); else passes++;
    checks++; if (r !== 32'h0) $display("FAIL ovf_rem got %h want 00000000", r); else passes++;
    launch(32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL umax_1_quo got %h want FFFFFFFF", q); else passes++;
    checks++; if (r !== 32'h0) $display("FAIL umax_1_rem got %h want 00000000", r); else passes++;
  endtask

  task automatic test_abort();
    logic [31:0] q, r;
    int lat, bcyc;
    int seen;
    launch(32'd100, 32'd7, 1'b0);
    wait_done(q, r, lat, bcyc);
    launch(32'd1000, 32'd3, 1'b0);
    seen = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (bus.div_done) seen++;
    end
    bus.E_div_abort = 1'b1;
    @(posedge clk);
    #1;
    bus.E_div_abort = 1'b0;
    if (bus.div_done) seen++;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.div_busy); else passes++;
    checks++; if (seen !== 0) $display("FAIL abort_no_done got %0d dones want 0", seen); else passes++;
    checks++; if (bus.div_quotient !== 32'd14) $display("FAIL abort_quo_kept got %h want %h", bus.div_quotient, 32'd14); else passes++;
    checks++; if (bus.div_remainder !== 32'd2) $display("FAIL abort_rem_kept got %h want %h", bus.div_remainder, 32'd2); else passes++;
    launch(32'd9, 32'd4, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (lat !== 33) $display("FAIL restart_latency got %0d want 33", lat); else passes++;
    checks++; if (q !== 32'd2) $display("FAIL restart_quo got %h want 2", q); else passes++;
    checks++; if (r !== 32'd1) $display("FAIL restart_rem got %h want 1", r); else passes++;
    bus.E_div_abort = 1'b1;
    launch(32'd50, 32'd5, 1'b0);
    bus.E_div_abort = 1'b0;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL abort_beats_start got busy %b want 0", bus.div_busy); else passes++;
  endtask

  task automatic test_start_while_busy();
    logic [31:0] q, r;
    int lat, bcyc;
    int seen;
    launch(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.E_src1 = 32'd50; bus.E_src2 = 32'd5; bus.E_div_start = 1'b1;
    @(posedge clk);
    #1;
    bus.E_div_start = 1'b0;
    wait_done(q, r, lat, bcyc);
    checks++; if (lat !== 27) $display("FAIL swb_latency got %0d want 27", lat); else passes++;
    checks++; if (q !== 32'd14) $display("FAIL swb_quo got %h want %h", q, 32'd14); else passes++;
    checks++; if (r !== 32'd2) $display("FAIL swb_rem got %h want %h", r, 32'd2); else passes++;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.div_done || bus.div_busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL swb_not_queued got %0d active cycles want 0", seen); else passes++;
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    launch(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.div_busy !== 1'b0) $display("FAIL areset_busy got %b want 0", bus.div_busy); else passes++;
    checks++; if (bus.div_quotient !== 32'h0) $display("FAIL areset_quo got %h want 0", bus.div_quotient); else passes++;
    checks++; if (bus.div_remainder !== 32'h0) $display("FAIL areset_rem got %h want 0", bus.div_remainder); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.div_done || bus.div_busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL areset_no_done got %0d active cycles want 0", seen); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    int lat, bcyc;
    launch(32'd100, 32'd7, 1'b0);
    wait_done(q, r, lat, bcyc);
    checks++; if (q !== 32'd14) $display("FAIL b2b_first_quo got %h want %h", q, 32'd14); else passes++;
    launch(32'd1000, 32'd3, 1'b0);
    checks++; if (bus.div_busy !== 1'b1) $display("FAIL b2b_accept got busy %b want 1", bus.div_busy); else passes++;
    wait_done(q, r, lat, bcyc);
    checks++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else passes++;
    checks++; if (q !== 32'd333) $display("FAIL b2b_quo got %h want %h", q, 32'd333); else passes++;
    checks++; if (r !== 32'd1) $display("FAIL b2b_rem got %h want 1", r); else passes++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_edge_cases();
    test_abort();
    test_start_while_busy();
    test_reset_mid_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
